pattern_seq_detector: RTL

PATTERN_SEQ_DETECTOR -- requirements
Module: pattern_seq_detector

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/sat_counter.sv | 25 ++
 rtl/pattern_seq_detector.sv | 83 ++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package seq_det_pkg;
  localparam int PAT_LEN_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    FILL    = 2'd1,
    DETECT  = 2'd2
  } det_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/pattern_seq_detector.sv
// Serial bit-pattern detector with overlap / non-overlap modes and a saturating match count.
module pattern_seq_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap_en,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clr_count,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);
  localparam int HIST_W = PAT_LEN - 1;
  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HIST_W);

  det_state_e          state_q;
  logic [PAT_LEN-1:0]  pat_q;
  logic [HIST_W-1:0]   hist_q;
  logic [FILL_W-1:0]   fill_q;
  logic                match_q, armed_q;

  logic [PAT_LEN-1:0]  window;
  logic [HIST_W-1:0]   hist_d;
  logic [FILL_W-1:0]   fill_inc;
  logic                beat, hit;

  // Oldest history bit lines up with the pattern MSB.
  assign window   = {hist_q, in_bit};
  assign hist_d   = window[HIST_W-1:0];
  assign fill_inc = fill_q + FILL_W'(1);
  // A pat_load cycle swallows any concurrent beat.
  assign beat     = in_valid && !pat_load && (state_q != UNARMED);
  assign hit      = beat && (state_q == DETECT) && (window == pat_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNARMED;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (pat_load) begin
        pat_q   <= pat_in;
        hist_q  <= '0;
        fill_q  <= '0;
        state_q <= FILL;
        armed_q <= 1'b1;
      end else if (beat) begin
        if (hit && !overlap_en) begin
          hist_q  <= '0;
          fill_q  <= '0;
          state_q <= FILL;
        end else begin
          hist_q <= hist_d;
          if (fill_q != FILL_FULL) fill_q <= fill_inc;
          if (state_q == FILL && fill_inc == FILL_FULL) state_q <= DETECT;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_count),
    .inc   (hit),
    .count (match_count)
  );

  assign armed = armed_q;
  assign match = match_q;
endmodule
